// File: rtl/q_cache_pingpong_ctrl_if.sv
// Bus bundle between the Q alignment stage, the ping-pong controller and the Q buffer SRAM.
// The master modport is the controller side; slave is the alignment stage / SRAM side.
interface q_cache_pingpong_ctrl_if #(
  parameter int ADDR_W    = 2,
  parameter int DATA_W    = 128,
  parameter int EXP_WIDTH = 8,
  parameter int RPL_W     = 6
);
  logic [RPL_W-1:0]     cfg_replay;
  logic [EXP_WIDTH-1:0] exp_max;
  logic [DATA_W-1:0]    mant_in;
  logic                 mant_in_vld;
  logic                 mant_in_rdy;
  logic                 q_buf_wr_en;
  logic                 q_buf_wr_bank;
  logic [ADDR_W-1:0]    q_buf_wr_addr;
  logic [DATA_W-1:0]    q_buf_wr_data;
  logic [EXP_WIDTH-1:0] q_buf_wr_exp;
  logic                 q_buf_rd_en;
  logic                 q_buf_rd_bank;
  logic [ADDR_W-1:0]    q_buf_rd_addr;
  logic                 q_buf_rd_rdy;
  logic                 q_buf_rd_last;
  logic [1:0]           bank_full;

  modport master (
    input  cfg_replay, exp_max, mant_in, mant_in_vld, q_buf_rd_rdy,
    output mant_in_rdy, q_buf_wr_en, q_buf_wr_bank, q_buf_wr_addr, q_buf_wr_data,
           q_buf_wr_exp, q_buf_rd_en, q_buf_rd_bank, q_buf_rd_addr, q_buf_rd_last,
           bank_full
  );

  modport slave (
    output cfg_replay, exp_max, mant_in, mant_in_vld, q_buf_rd_rdy,
    input  mant_in_rdy, q_buf_wr_en, q_buf_wr_bank, q_buf_wr_addr, q_buf_wr_data,
           q_buf_wr_exp, q_buf_rd_en, q_buf_rd_bank, q_buf_rd_addr, q_buf_rd_last,
           bank_full
  );
endinterface

// File: rtl/q_cache_pingpong_ctrl.sv
// Double-buffered Q cache controller: one bank fills from the alignment stage while the
// other bank is replayed a programmable number of passes.
//
// state      | meaning
// ST_EMPTY   | bank free, writer may start filling it
// ST_FILLING | writes in progress, not readable yet
// ST_FULL    | last write has landed in the SRAM, waiting for first read
// ST_READING | replay passes in progress
module q_cache_pingpong_ctrl #(
  parameter int Q_DEPTH   = 4,
  parameter int ADDR_W    = $clog2(Q_DEPTH),
  parameter int DATA_W    = 128,
  parameter int EXP_WIDTH = 8,
  parameter int RPL_W     = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  q_cache_pingpong_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2,
    ST_READING = 2'd3
  } bank_st_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(Q_DEPTH - 1);

  bank_st_e             bank_st [2];
  bank_st_e             bank_nx [2];
  logic                 run_q;
  logic                 wr_bank;
  logic                 rd_bank;
  logic [ADDR_W-1:0]    wr_addr;
  logic [ADDR_W-1:0]    rd_addr;
  logic [RPL_W-1:0]     rpl_cnt;
  logic [RPL_W-1:0]     rpl_tgt [2];
  logic [RPL_W-1:0]     cfg_tgt;
  logic [RPL_W-1:0]     rd_tgt_m1;
  logic                 wr_acc;
  logic                 rd_en;
  logic                 rd_acc;
  logic                 rd_wrap;
  logic                 rd_final;
  logic                 wr_en_q;
  logic                 wr_bank_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [DATA_W-1:0]    wr_data_q;
  logic [EXP_WIDTH-1:0] wr_exp_q;

  // run_q keeps every output, including ready, at 0 while reset is applied
  assign bus.mant_in_rdy = run_q & ((bank_st[wr_bank] == ST_EMPTY) ||
                                    (bank_st[wr_bank] == ST_FILLING));
  assign wr_acc    = bus.mant_in_vld & bus.mant_in_rdy;
  assign cfg_tgt   = (bus.cfg_replay == '0) ? RPL_W'(1) : bus.cfg_replay;

  assign rd_en     = (bank_st[rd_bank] == ST_FULL) || (bank_st[rd_bank] == ST_READING);
  assign rd_acc    = rd_en & bus.q_buf_rd_rdy;
  assign rd_wrap   = (rd_addr == LAST_ADDR);
  assign rd_tgt_m1 = rpl_tgt[rd_bank] - RPL_W'(1);
  assign rd_final  = rd_wrap && (rpl_cnt == rd_tgt_m1);

  assign bus.q_buf_wr_en   = wr_en_q;
  assign bus.q_buf_wr_bank = wr_bank_q;
  assign bus.q_buf_wr_addr = wr_addr_q;
  assign bus.q_buf_wr_data = wr_data_q;
  assign bus.q_buf_wr_exp  = wr_exp_q;
  assign bus.q_buf_rd_en   = rd_en;
  assign bus.q_buf_rd_bank = rd_bank;
  assign bus.q_buf_rd_addr = rd_addr;
  assign bus.q_buf_rd_last = rd_en & rd_final;
  assign bus.bank_full     = {(bank_st[1] == ST_FULL) || (bank_st[1] == ST_READING),
                              (bank_st[0] == ST_FULL) || (bank_st[0] == ST_READING)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0] <= ST_EMPTY;
      bank_st[1] <= ST_EMPTY;
    end else begin
      bank_st[0] <= bank_nx[0];
      bank_st[1] <= bank_nx[1];
    end
  end

  // FULL waits for the registered write of the last entry, so reads never overtake writes
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_nx[b] = bank_st[b];
      case (bank_st[b])
        ST_EMPTY:   if (wr_acc && (wr_bank == b[0])) bank_nx[b] = ST_FILLING;
        ST_FILLING: if (wr_en_q && (wr_bank_q == b[0]) && (wr_addr_q == LAST_ADDR))
                      bank_nx[b] = ST_FULL;
        ST_FULL:    if (rd_acc && (rd_bank == b[0])) bank_nx[b] = ST_READING;
        ST_READING: if (rd_acc && (rd_bank == b[0]) && rd_final) bank_nx[b] = ST_EMPTY;
        default:    bank_nx[b] = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      wr_bank    <= 1'b0;
      wr_addr    <= '0;
      rpl_tgt[0] <= '0;
      rpl_tgt[1] <= '0;
      wr_en_q    <= 1'b0;
      wr_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_exp_q   <= '0;
    end else begin
      run_q   <= 1'b1;
      wr_en_q <= wr_acc;
      if (wr_acc) begin
        wr_bank_q <= wr_bank;
        wr_addr_q <= wr_addr;
        wr_data_q <= bus.mant_in;
        wr_exp_q  <= bus.exp_max;
        if (wr_addr == LAST_ADDR) begin
          wr_addr          <= '0;
          wr_bank          <= ~wr_bank;
          rpl_tgt[wr_bank] <= cfg_tgt;
        end else begin
          wr_addr <= wr_addr + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank <= 1'b0;
      rd_addr <= '0;
      rpl_cnt <= '0;
    end else if (rd_acc) begin
      if (rd_wrap) begin
        rd_addr <= '0;
        if (rd_final) begin
          rpl_cnt <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rpl_cnt <= rpl_cnt + RPL_W'(1);
        end
      end else begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_q_cache_pingpong_ctrl.sv
// Directed bench for q_cache_pingpong_ctrl: a Q_DEPTH=4 instance for most scenarios and a
// Q_DEPTH=5 instance for non-power-of-2 wrapping.
module tb_q_cache_pingpong_ctrl;
  localparam int DATA_W = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  q_cache_pingpong_ctrl_if #(.ADDR_W(2), .DATA_W(DATA_W), .EXP_WIDTH(8), .RPL_W(6)) bus ();
  q_cache_pingpong_ctrl_if #(.ADDR_W(3), .DATA_W(DATA_W), .EXP_WIDTH(8), .RPL_W(6)) bus5 ();

  q_cache_pingpong_ctrl #(.Q_DEPTH(4), .ADDR_W(2), .DATA_W(DATA_W), .EXP_WIDTH(8), .RPL_W(6))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  q_cache_pingpong_ctrl #(.Q_DEPTH(5), .ADDR_W(3), .DATA_W(DATA_W), .EXP_WIDTH(8), .RPL_W(6))
    dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] dat(input int k);
    return {4{32'h5A5A_0000 | 32'(k)}};
  endfunction

  function automatic logic [7:0] expv(input int k);
    return 8'(k + 16);
  endfunction

  task automatic idle_inputs();
    bus.mant_in_vld   = 1'b0;
    bus.q_buf_rd_rdy  = 1'b0;
    bus.mant_in       = '0;
    bus.exp_max       = '0;
    bus.cfg_replay    = 6'd1;
    bus5.mant_in_vld  = 1'b0;
    bus5.q_buf_rd_rdy = 1'b0;
    bus5.mant_in      = '0;
    bus5.exp_max      = '0;
    bus5.cfg_replay   = 6'd1;
  endtask

  // leaves the bench at posedge+1 of the first cycle the controller is running
  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.mant_in_rdy, bus.q_buf_wr_en, bus.q_buf_wr_bank, bus.q_buf_wr_addr,
         bus.q_buf_wr_data, bus.q_buf_wr_exp, bus.q_buf_rd_en, bus.q_buf_rd_bank,
         bus.q_buf_rd_addr, bus.q_buf_rd_last, bus.bank_full} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b wr_en=%b rd_en=%b rd_addr=%h bank_full=%b, required all 0",
               bus.mant_in_rdy, bus.q_buf_wr_en, bus.q_buf_rd_en, bus.q_buf_rd_addr, bus.bank_full);
    end
    n_chk++;
    if ({bus5.mant_in_rdy, bus5.q_buf_wr_en, bus5.q_buf_rd_en, bus5.q_buf_rd_addr,
         bus5.q_buf_wr_addr, bus5.bank_full} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_q5: rdy=%b wr_en=%b rd_en=%b bank_full=%b, required all 0",
               bus5.mant_in_rdy, bus5.q_buf_wr_en, bus5.q_buf_rd_en, bus5.bank_full);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if ({bus.mant_in_rdy, bus.q_buf_rd_en, bus.bank_full} !== 4'b1000) begin
      n_fail++;
      $display("FAIL post_reset_idle: rdy=%b rd_en=%b bank_full=%b, required rdy=1 rd_en=0 bank_full=00",
               bus.mant_in_rdy, bus.q_buf_rd_en, bus.bank_full);
    end
  endtask

  // shared by the replay=3 and replay=0 scenarios: 4 writes then n_rd reads of bank 0
  task automatic run_single_bank(input string tag, input logic [5:0] cfg, input int n_rd);
    apply_reset();
    bus.cfg_replay   = cfg;
    bus.q_buf_rd_rdy = 1'b1;
    for (int t = 0; t < n_rd + 6; t++) begin
      bus.mant_in_vld = (t < 4);
      bus.mant_in     = dat(t);
      bus.exp_max     = expv(t);
      @(negedge clk);
      if (t < 4) begin
        n_chk++;
        if (bus.mant_in_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_rdy t=%0d: got %b, required 1", tag, t, bus.mant_in_rdy);
        end
      end
      n_chk++;
      if (t >= 1 && t <= 4) begin
        if ({bus.q_buf_wr_en, bus.q_buf_wr_bank, bus.q_buf_wr_addr, bus.q_buf_wr_data, bus.q_buf_wr_exp}
            !== {1'b1, 1'b0, 2'(t - 1), dat(t - 1), expv(t - 1)}) begin
          n_fail++;
          $display("FAIL %s_write t=%0d: got en=%b bank=%b addr=%0d data=%h exp=%h, required en=1 bank=0 addr=%0d data=%h exp=%h",
                   tag, t, bus.q_buf_wr_en, bus.q_buf_wr_bank, bus.q_buf_wr_addr, bus.q_buf_wr_data,
                   bus.q_buf_wr_exp, t - 1, dat(t - 1), expv(t - 1));
        end
      end else if (bus.q_buf_wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_write_idle t=%0d: got wr_en=%b, required 0", tag, t, bus.q_buf_wr_en);
      end
      n_chk++;
      if (t >= 5 && t < 5 + n_rd) begin
        if ({bus.q_buf_rd_en, bus.q_buf_rd_bank, bus.q_buf_rd_addr, bus.q_buf_rd_last}
            !== {1'b1, 1'b0, 2'((t - 5) % 4), (t == 4 + n_rd)}) begin
          n_fail++;
          $display("FAIL %s_read t=%0d: got en=%b bank=%b addr=%0d last=%b, required en=1 bank=0 addr=%0d last=%b",
                   tag, t, bus.q_buf_rd_en, bus.q_buf_rd_bank, bus.q_buf_rd_addr, bus.q_buf_rd_last,
                   (t - 5) % 4, (t == 4 + n_rd));
        end
      end else if ({bus.q_buf_rd_en, bus.q_buf_rd_last} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s_read_idle t=%0d: got rd_en=%b last=%b, required 0 0",
                 tag, t, bus.q_buf_rd_en, bus.q_buf_rd_last);
      end
      if (t == 5 || t == 5 + n_rd) begin
        n_chk++;
        if (bus.bank_full !== ((t == 5) ? 2'b01 : 2'b00)) begin
          n_fail++;
          $display("FAIL %s_bank_full t=%0d: got %b, required %b", tag, t, bus.bank_full,
                   (t == 5) ? 2'b01 : 2'b00);
        end
      end
      @(posedge clk); #1;
    end
    bus.mant_in_vld = 1'b0;
  endtask

  task automatic test_fill_replay();
    run_single_bank("replay3", 6'd3, 12);
  endtask

  task automatic test_replay_zero();
    run_single_bank("replay0", 6'd0, 4);
  endtask

  task automatic test_back_to_back();
    logic [12:0] e_rdy, e_rd_en, e_rd_bank, e_rd_last;
    int          n_acc    = 0;
    int          prev_t   = 0;
    logic        prev_acc = 1'b0;
    logic        exp_wb   = 1'b0;
    logic [1:0]  exp_wa   = 2'd0;
    e_rdy     = 13'b1_1110_1111_1111;
    e_rd_en   = 13'b1_1111_1110_0000;
    e_rd_bank = 13'b1_1110_0000_0000;
    e_rd_last = 13'b1_0001_0000_0000;
    apply_reset();
    bus.cfg_replay   = 6'd1;
    bus.q_buf_rd_rdy = 1'b1;
    for (int t = 0; t < 13; t++) begin
      bus.mant_in_vld = 1'b1;
      bus.mant_in     = dat(t + 100);
      @(negedge clk);
      n_chk++;
      if (bus.mant_in_rdy !== e_rdy[t]) begin
        n_fail++;
        $display("FAIL b2b_rdy t=%0d: got %b, required %b", t, bus.mant_in_rdy, e_rdy[t]);
      end
      n_chk++;
      if (prev_acc) begin
        if ({bus.q_buf_wr_en, bus.q_buf_wr_bank, bus.q_buf_wr_addr, bus.q_buf_wr_data}
            !== {1'b1, exp_wb, exp_wa, dat(prev_t + 100)}) begin
          n_fail++;
          $display("FAIL b2b_write t=%0d: got en=%b bank=%b addr=%0d data=%h, required en=1 bank=%b addr=%0d data=%h",
                   t, bus.q_buf_wr_en, bus.q_buf_wr_bank, bus.q_buf_wr_addr, bus.q_buf_wr_data,
                   exp_wb, exp_wa, dat(prev_t + 100));
        end
      end else if (bus.q_buf_wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_write_idle t=%0d: got wr_en=%b, required 0", t, bus.q_buf_wr_en);
      end
      n_chk++;
      if ({bus.q_buf_rd_en, bus.q_buf_rd_last} !== {e_rd_en[t], e_rd_last[t]}) begin
        n_fail++;
        $display("FAIL b2b_read_ctl t=%0d: got en=%b last=%b, required en=%b last=%b",
                 t, bus.q_buf_rd_en, bus.q_buf_rd_last, e_rd_en[t], e_rd_last[t]);
      end
      if (e_rd_en[t]) begin
        n_chk++;
        if ({bus.q_buf_rd_bank, bus.q_buf_rd_addr} !== {e_rd_bank[t], 2'((t - 5) % 4)}) begin
          n_fail++;
          $display("FAIL b2b_read_addr t=%0d: got bank=%b addr=%0d, required bank=%b addr=%0d",
                   t, bus.q_buf_rd_bank, bus.q_buf_rd_addr, e_rd_bank[t], (t - 5) % 4);
        end
      end
      if (t == 6 || t == 9) begin
        n_chk++;
        if (bus.bank_full !== ((t == 6) ? 2'b01 : 2'b10)) begin
          n_fail++;
          $display("FAIL b2b_bank_full t=%0d: got %b, required %b", t, bus.bank_full,
                   (t == 6) ? 2'b01 : 2'b10);
        end
      end
      prev_acc = e_rdy[t];
      if (e_rdy[t]) begin
        exp_wb = 1'((n_acc / 4) % 2);
        exp_wa = 2'(n_acc % 4);
        n_acc++;
        prev_t = t;
      end
      @(posedge clk); #1;
    end
    bus.mant_in_vld = 1'b0;
  endtask

  task automatic test_random_rdy();
    int         n_rd       = 0;
    logic       prev_stall = 1'b0;
    logic       prev_bank  = 1'b0;
    logic [1:0] prev_addr  = 2'd0;
    apply_reset();
    bus.cfg_replay = 6'd2;
    for (int c = 0; c < 400 && n_rd < 8; c++) begin
      bus.mant_in_vld  = (c < 4);
      bus.mant_in      = dat(c + 200);
      bus.q_buf_rd_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prev_stall) begin
        n_chk++;
        if ({bus.q_buf_rd_en, bus.q_buf_rd_bank, bus.q_buf_rd_addr} !== {1'b1, prev_bank, prev_addr}) begin
          n_fail++;
          $display("FAIL rnd_hold c=%0d: got en=%b bank=%b addr=%0d, required en=1 bank=%b addr=%0d",
                   c, bus.q_buf_rd_en, bus.q_buf_rd_bank, bus.q_buf_rd_addr, prev_bank, prev_addr);
        end
      end
      if (bus.q_buf_rd_en && bus.q_buf_rd_rdy) begin
        n_chk++;
        if ({bus.q_buf_rd_bank, bus.q_buf_rd_addr, bus.q_buf_rd_last} !== {1'b0, 2'(n_rd % 4), (n_rd == 7)}) begin
          n_fail++;
          $display("FAIL rnd_seq read#%0d: got bank=%b addr=%0d last=%b, required bank=0 addr=%0d last=%b",
                   n_rd, bus.q_buf_rd_bank, bus.q_buf_rd_addr, bus.q_buf_rd_last, n_rd % 4, (n_rd == 7));
        end
        n_rd++;
      end
      prev_stall = bus.q_buf_rd_en && !bus.q_buf_rd_rdy;
      prev_bank  = bus.q_buf_rd_bank;
      prev_addr  = bus.q_buf_rd_addr;
      @(posedge clk); #1;
    end
    n_chk++;
    if (n_rd != 8) begin
      n_fail++;
      $display("FAIL rnd_count: got %0d accepted reads within bound, required 8", n_rd);
    end
    bus.q_buf_rd_rdy = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({bus.q_buf_rd_en, bus.bank_full} !== 3'b000) begin
      n_fail++;
      $display("FAIL rnd_release: got rd_en=%b bank_full=%b, required 0 00", bus.q_buf_rd_en, bus.bank_full);
    end
  endtask

  task automatic test_depth5_wrap();
    apply_reset();
    bus5.cfg_replay   = 6'd2;
    bus5.q_buf_rd_rdy = 1'b1;
    for (int t = 0; t < 17; t++) begin
      bus5.mant_in_vld = (t < 6);
      bus5.mant_in     = dat(t + 300);
      @(negedge clk);
      if (t >= 1 && t <= 6) begin
        n_chk++;
        if ({bus5.q_buf_wr_en, bus5.q_buf_wr_bank, bus5.q_buf_wr_addr, bus5.q_buf_wr_data}
            !== {1'b1, 1'((t - 1) / 5), 3'((t - 1) % 5), dat(t + 299)}) begin
          n_fail++;
          $display("FAIL q5_write t=%0d: got en=%b bank=%b addr=%0d, required en=1 bank=%0d addr=%0d",
                   t, bus5.q_buf_wr_en, bus5.q_buf_wr_bank, bus5.q_buf_wr_addr, (t - 1) / 5, (t - 1) % 5);
        end
      end
      n_chk++;
      if (t >= 6 && t <= 15) begin
        if ({bus5.q_buf_rd_en, bus5.q_buf_rd_bank, bus5.q_buf_rd_addr, bus5.q_buf_rd_last}
            !== {1'b1, 1'b0, 3'((t - 6) % 5), (t == 15)}) begin
          n_fail++;
          $display("FAIL q5_read t=%0d: got en=%b bank=%b addr=%0d last=%b, required en=1 bank=0 addr=%0d last=%b",
                   t, bus5.q_buf_rd_en, bus5.q_buf_rd_bank, bus5.q_buf_rd_addr, bus5.q_buf_rd_last,
                   (t - 6) % 5, (t == 15));
        end
      end else if (bus5.q_buf_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL q5_read_idle t=%0d: got rd_en=%b, required 0", t, bus5.q_buf_rd_en);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_chk++;
    if ({bus5.q_buf_rd_bank, bus5.bank_full} !== 3'b100) begin
      n_fail++;
      $display("FAIL q5_filling_not_read: got rd_bank=%b bank_full=%b, required 1 00",
               bus5.q_buf_rd_bank, bus5.bank_full);
    end
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    bus.cfg_replay   = 6'd3;
    bus.q_buf_rd_rdy = 1'b1;
    for (int t = 0; t < 7; t++) begin
      bus.mant_in_vld = (t < 6);
      bus.mant_in     = dat(t + 400);
      bus.exp_max     = expv(t);
      @(negedge clk);
      if (t == 6) begin
        n_chk++;
        if ({bus.q_buf_rd_en, bus.bank_full, bus.q_buf_wr_bank} !== 4'b1011) begin
          n_fail++;
          $display("FAIL midrst_setup: got rd_en=%b bank_full=%b wr_bank=%b, required 1 01 1",
                   bus.q_buf_rd_en, bus.bank_full, bus.q_buf_wr_bank);
        end
      end
      @(posedge clk); #1;
    end
    bus.mant_in_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.mant_in_rdy, bus.q_buf_wr_en, bus.q_buf_wr_bank, bus.q_buf_wr_addr,
         bus.q_buf_wr_data, bus.q_buf_wr_exp, bus.q_buf_rd_en, bus.q_buf_rd_bank,
         bus.q_buf_rd_addr, bus.q_buf_rd_last, bus.bank_full} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: rdy=%b wr_en=%b wr_addr=%0d rd_en=%b rd_addr=%0d bank_full=%b, required all 0",
               bus.mant_in_rdy, bus.q_buf_wr_en, bus.q_buf_wr_addr, bus.q_buf_rd_en,
               bus.q_buf_rd_addr, bus.bank_full);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.mant_in_vld = 1'b1;
    bus.mant_in     = dat(99);
    bus.exp_max     = expv(99);
    @(negedge clk);
    n_chk++;
    if (bus.mant_in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_rdy: got %b, required 1", bus.mant_in_rdy);
    end
    @(posedge clk); #1;
    bus.mant_in_vld = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.q_buf_wr_en, bus.q_buf_wr_bank, bus.q_buf_wr_addr, bus.q_buf_wr_data, bus.q_buf_rd_en}
        !== {1'b1, 1'b0, 2'd0, dat(99), 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_first_write: got en=%b bank=%b addr=%0d data=%h rd_en=%b, required en=1 bank=0 addr=0 data=%h rd_en=0",
               bus.q_buf_wr_en, bus.q_buf_wr_bank, bus.q_buf_wr_addr, bus.q_buf_wr_data,
               bus.q_buf_rd_en, dat(99));
    end
  endtask

  initial begin
    test_reset();
    test_fill_replay();
    test_back_to_back();
    test_random_rdy();
    test_replay_zero();
    test_depth5_wrap();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
